multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 35 +++
 rtl/multicycle_control_mem_wait_timer.sv | 26 ++
 rtl/multicycle_control.sv | 152 +++++++++++++++
 tb/tb_multicycle_control.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: instruction types,
// FSM state encodings, fault codes and the immediate extensor.
package multicycle_control_pkg;

    localparam logic [4:0] DATA_TRANSFER          = 5'b00000;
    localparam logic [4:0] ARITHMETIC_AND_LOGICAL = 5'b00001;
    localparam logic [4:0] CONTROL_TRANSFER       = 5'b00010;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXEC_AL = 3'd2,
        EXEC_DT = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        BRANCH  = 3'd6,
        HALT    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_ILLEGAL = 2'b01,
        FAULT_BUS     = 2'b10
    } fault_t;

    // Branches carry a 27-bit offset; data and ALU ops a 16-bit immediate.
    function automatic logic [31:0] imm_extend(input logic [31:0] instr);
        case (instr[31:27])
            CONTROL_TRANSFER:                      return {{5{instr[26]}}, instr[26:0]};
            DATA_TRANSFER, ARITHMETIC_AND_LOGICAL: return {{16{instr[15]}}, instr[15:0]};
            default:                               return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; expired fires on the wait
// cycle that brings the count up to MEM_TIMEOUT.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clock,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (count_en && count != CW'(MEM_TIMEOUT)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = count_en && (count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback
// sequencing with a memory-wait timeout and a retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_branch,
    output logic        alu_src_imm,
    output logic        reg_write,
    output logic        wb_sel,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [31:0] retired,
    output state_t      debug_state
);

    state_t state;
    logic   in_wait_state;
    logic   timer_clear;
    logic   timer_count_en;
    logic   timeout;
    logic   unused_instr;

    assign in_wait_state  = (state == FETCH) || (state == MEM);
    assign timer_clear    = reset || !in_wait_state || mem_ready;
    assign timer_count_en = mem_req && !mem_ready;
    assign debug_state    = state;
    assign unused_instr   = ^instruction[25:0];

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clock    (clock),
        .clear    (timer_clear),
        .count_en (timer_count_en),
        .expired  (timeout)
    );

    // IR/PC load must land in the same cycle the fetched word is valid,
    // otherwise DECODE would see the previous instruction.
    assign ir_write = (state == FETCH) && mem_req && mem_ready;
    assign pc_write = ir_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= FETCH;
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr_sel <= 1'b0;
            pc_branch    <= 1'b0;
            alu_src_imm  <= 1'b0;
            reg_write    <= 1'b0;
            wb_sel       <= 1'b0;
            halted       <= 1'b0;
            fault        <= FAULT_NONE;
            retired      <= '0;
        end else begin
            pc_branch   <= 1'b0;
            reg_write   <= 1'b0;
            alu_src_imm <= 1'b0;
            case (state)
                FETCH: begin
                    if (timeout) begin
                        state   <= HALT;
                        mem_req <= 1'b0;
                        halted  <= 1'b1;
                        fault   <= FAULT_BUS;
                    end else if (mem_ready) begin
                        state   <= DECODE;
                        mem_req <= 1'b0;
                    end
                end
                DECODE: begin
                    case (instruction[31:27])
                        DATA_TRANSFER: begin
                            state       <= EXEC_DT;
                            alu_src_imm <= 1'b1;
                        end
                        ARITHMETIC_AND_LOGICAL: begin
                            state       <= EXEC_AL;
                            alu_src_imm <= 1'b1;
                        end
                        CONTROL_TRANSFER: begin
                            state     <= BRANCH;
                            pc_branch <= 1'b1;
                        end
                        default: begin
                            state  <= HALT;
                            halted <= 1'b1;
                            fault  <= FAULT_ILLEGAL;
                        end
                    endcase
                end
                EXEC_AL: begin
                    state     <= WB;
                    wb_sel    <= 1'b0;
                    reg_write <= 1'b1;
                end
                EXEC_DT: begin
                    state        <= MEM;
                    mem_req      <= 1'b1;
                    mem_addr_sel <= 1'b1;
                    mem_we       <= instruction[26];
                end
                MEM: begin
                    if (timeout) begin
                        state        <= HALT;
                        mem_req      <= 1'b0;
                        mem_we       <= 1'b0;
                        mem_addr_sel <= 1'b0;
                        halted       <= 1'b1;
                        fault        <= FAULT_BUS;
                    end else if (mem_ready) begin
                        mem_we       <= 1'b0;
                        mem_addr_sel <= 1'b0;
                        // The registered mem_we tells store from load.
                        if (mem_we) begin
                            state   <= FETCH;
                            mem_req <= 1'b1;
                            retired <= retired + 32'd1;
                        end else begin
                            state     <= WB;
                            mem_req   <= 1'b0;
                            wb_sel    <= 1'b1;
                            reg_write <= 1'b1;
                        end
                    end
                end
                WB, BRANCH: begin
                    state   <= FETCH;
                    mem_req <= 1'b1;
                    retired <= retired + 32'd1;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: cycle-by-cycle vector table plus
// hand-written HALT, timeout and reset-priority sequences.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam logic [31:0] I_AL  = 32'h0800_0000;
    localparam logic [31:0] I_BR  = 32'h1000_0040;
    localparam logic [31:0] I_LD  = 32'h0000_1234;
    localparam logic [31:0] I_ST  = 32'h0400_0010;
    localparam logic [31:0] I_ILL = 32'h3800_0000;

    // ctl = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write,
    //        pc_branch, alu_src_imm, reg_write, wb_sel, halted}
    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        rdy;
        state_t      st;
        logic [9:0]  ctl;
        logic [1:0]  flt;
        logic [31:0] ret;
    } vec_t;

    logic        clock;
    logic        reset;
    logic [31:0] instruction;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic        pc_branch;
    logic        alu_src_imm;
    logic        reg_write;
    logic        wb_sel;
    logic        halted;
    logic [1:0]  fault;
    logic [31:0] retired;
    state_t      debug_state;

    int tests_run    = 0;
    int tests_failed = 0;
    vec_t tbl[$];

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .instruction  (instruction),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_branch    (pc_branch),
        .alu_src_imm  (alu_src_imm),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .halted       (halted),
        .fault        (fault),
        .retired      (retired),
        .debug_state  (debug_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, input logic [31:0] instr, input logic rdy,
                                input state_t st, input logic [9:0] ctl, input logic [1:0] flt,
                                input logic [31:0] ret);
        vec_t v;
        v.rst = rst; v.instr = instr; v.rdy = rdy;
        v.st = st; v.ctl = ctl; v.flt = flt; v.ret = ret;
        return v;
    endfunction

    // Drive one cycle's inputs at the falling edge, then check outputs.
    task automatic apply(input string tag, input vec_t v);
        logic [9:0] got_ctl;
        @(negedge clock);
        reset       = v.rst;
        instruction = v.instr;
        mem_ready   = v.rdy;
        #1;
        got_ctl = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write,
                   pc_branch, alu_src_imm, reg_write, wb_sel, halted};
        tests_run++;
        if (debug_state !== v.st || got_ctl !== v.ctl || fault !== v.flt || retired !== v.ret) begin
            tests_failed++;
            $display("FAIL %s: got state=%0d ctl=%b fault=%b retired=%0d, expected state=%0d ctl=%b fault=%b retired=%0d",
                     tag, debug_state, got_ctl, fault, retired, v.st, v.ctl, v.flt, v.ret);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic [31:0] instr, input logic rdy,
                        input state_t st, input logic [9:0] ctl, input logic [1:0] flt,
                        input logic [31:0] ret);
        apply(tag, mk(rst, instr, rdy, st, ctl, flt, ret));
    endtask

    initial begin
        reset       = 1'b1;
        instruction = 32'd0;
        mem_ready   = 1'b0;
        repeat (2) @(posedge clock);

        // AL, branch, load with 3 wait cycles, store, fetch wait, illegal type
        tbl.push_back(mk(0, I_AL,  1, FETCH,   10'b1001100000, 2'b00, 32'd0));
        tbl.push_back(mk(0, I_AL,  1, DECODE,  10'b0000000000, 2'b00, 32'd0));
        tbl.push_back(mk(0, I_AL,  1, EXEC_AL, 10'b0000001000, 2'b00, 32'd0));
        tbl.push_back(mk(0, I_AL,  1, WB,      10'b0000000100, 2'b00, 32'd0));
        tbl.push_back(mk(0, I_BR,  1, FETCH,   10'b1001100000, 2'b00, 32'd1));
        tbl.push_back(mk(0, I_BR,  1, DECODE,  10'b0000000000, 2'b00, 32'd1));
        tbl.push_back(mk(0, I_BR,  1, BRANCH,  10'b0000010000, 2'b00, 32'd1));
        tbl.push_back(mk(0, I_LD,  1, FETCH,   10'b1001100000, 2'b00, 32'd2));
        tbl.push_back(mk(0, I_LD,  1, DECODE,  10'b0000000000, 2'b00, 32'd2));
        tbl.push_back(mk(0, I_LD,  1, EXEC_DT, 10'b0000001000, 2'b00, 32'd2));
        tbl.push_back(mk(0, I_LD,  0, MEM,     10'b1010000000, 2'b00, 32'd2));
        tbl.push_back(mk(0, I_LD,  0, MEM,     10'b1010000000, 2'b00, 32'd2));
        tbl.push_back(mk(0, I_LD,  0, MEM,     10'b1010000000, 2'b00, 32'd2));
        tbl.push_back(mk(0, I_LD,  1, MEM,     10'b1010000000, 2'b00, 32'd2));
        tbl.push_back(mk(0, I_LD,  0, WB,      10'b0000000110, 2'b00, 32'd2));
        tbl.push_back(mk(0, I_ST,  1, FETCH,   10'b1001100010, 2'b00, 32'd3));
        tbl.push_back(mk(0, I_ST,  1, DECODE,  10'b0000000010, 2'b00, 32'd3));
        tbl.push_back(mk(0, I_ST,  1, EXEC_DT, 10'b0000001010, 2'b00, 32'd3));
        tbl.push_back(mk(0, I_ST,  1, MEM,     10'b1110000010, 2'b00, 32'd3));
        tbl.push_back(mk(0, I_ILL, 0, FETCH,   10'b1000000010, 2'b00, 32'd4));
        tbl.push_back(mk(0, I_ILL, 1, FETCH,   10'b1001100010, 2'b00, 32'd4));
        tbl.push_back(mk(0, I_ILL, 1, DECODE,  10'b0000000010, 2'b00, 32'd4));
        tbl.push_back(mk(0, I_ILL, 1, HALT,    10'b0000000011, 2'b01, 32'd4));

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // HALT absorbs: random inputs for 20 cycles, no strobes, values held
        for (int i = 0; i < 20; i++) begin
            step($sformatf("halt_hold%0d", i), 0, $urandom, 1'($urandom_range(0, 1)),
                 HALT, 10'b0000000011, 2'b01, 32'd4);
        end
        step("halt_reset",  1, I_AL, 1, HALT,  10'b0000000011, 2'b01, 32'd4);

        // FETCH timeout after four wait cycles
        step("to_wait1",    0, I_AL, 0, FETCH, 10'b1000000000, 2'b00, 32'd0);
        step("to_wait2",    0, I_AL, 0, FETCH, 10'b1000000000, 2'b00, 32'd0);
        step("to_wait3",    0, I_AL, 0, FETCH, 10'b1000000000, 2'b00, 32'd0);
        step("to_wait4",    0, I_AL, 0, FETCH, 10'b1000000000, 2'b00, 32'd0);
        step("to_halt",     0, I_AL, 1, HALT,  10'b0000000001, 2'b10, 32'd0);
        step("to_reset",    1, I_AL, 1, HALT,  10'b0000000001, 2'b10, 32'd0);

        // Reset during a MEM wait beats the pending timeout
        step("rm_fetch",    0, I_ST, 1, FETCH,   10'b1001100000, 2'b00, 32'd0);
        step("rm_decode",   0, I_ST, 1, DECODE,  10'b0000000000, 2'b00, 32'd0);
        step("rm_exec",     0, I_ST, 1, EXEC_DT, 10'b0000001000, 2'b00, 32'd0);
        step("rm_mem1",     0, I_ST, 0, MEM,     10'b1110000000, 2'b00, 32'd0);
        step("rm_mem2",     0, I_ST, 0, MEM,     10'b1110000000, 2'b00, 32'd0);
        step("rm_mem3",     0, I_ST, 0, MEM,     10'b1110000000, 2'b00, 32'd0);
        step("rm_mem4_rst", 1, I_ST, 0, MEM,     10'b1110000000, 2'b00, 32'd0);
        step("rm_after",    0, I_ST, 0, FETCH,   10'b1000000000, 2'b00, 32'd0);

        // Reset beats mem_ready in FETCH
        step("rf_rst_rdy",  1, I_AL, 1, FETCH,   10'b1001100000, 2'b00, 32'd0);
        step("rf_after",    0, I_AL, 0, FETCH,   10'b1000000000, 2'b00, 32'd0);
        step("rf_go",       0, I_AL, 1, FETCH,   10'b1001100000, 2'b00, 32'd0);
        step("rf_decode",   0, I_AL, 1, DECODE,  10'b0000000000, 2'b00, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
